// File: rtl/aes_128_round_sched.sv
// Iterative AES-128 encryption sequencer: initial AddRoundKey in-house, then rounds
// 1..NR issued one at a time to a shared external round datapath and key-schedule step.
module aes_128_round_sched #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         dp_issue,
    output logic         dp_final,
    output logic [127:0] dp_state,
    output logic [127:0] dp_key,
    input  logic [127:0] dp_result,
    output logic [127:0] ks_key,
    output logic [7:0]   ks_rcon,
    input  logic [127:0] ks_next
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [7:0]   rcon_q, rcon_d;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            st_q    <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
            rcon_q  <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            rcon_q  <= rcon_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        st_d      = st_q;
        key_d     = key_q;
        rnd_d     = rnd_q;
        rcon_d    = rcon_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_state = '0;
        dp_issue  = 1'b0;
        dp_final  = 1'b0;
        dp_state  = '0;
        dp_key    = '0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_d    = in_state ^ in_key;
                    key_d   = in_key;
                    rnd_d   = 4'd1;
                    rcon_d  = 8'h01;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The round key for this round comes straight from the key step.
                dp_issue = 1'b1;
                dp_state = st_q;
                dp_key   = ks_next;
                dp_final = (rnd_q == LAST_RND);
                key_d    = ks_next;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                st_d = dp_result;
                if (rnd_q == LAST_RND) begin
                    state_d = S_DONE;
                end else begin
                    rnd_d   = rnd_q + 4'd1;
                    rcon_d  = xtime(rcon_q);
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                out_state = st_q;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ks_key  = key_q;
    assign ks_rcon = rcon_q;

endmodule

// File: tb/tb_aes_128_round_sched.sv
// Bench for aes_128_round_sched: models the external round datapath and key step,
// and checks results against a whole-block AES-128 reference computed from first principles.
module tb_aes_128_round_sched;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         dp_issue;
    logic         dp_final;
    logic [127:0] dp_state;
    logic [127:0] dp_key;
    logic [127:0] dp_result;
    logic [127:0] ks_key;
    logic [7:0]   ks_rcon;
    logic [127:0] ks_next;

    aes_128_round_sched #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .dp_issue(dp_issue), .dp_final(dp_final), .dp_state(dp_state), .dp_key(dp_key),
        .dp_result(dp_result), .ks_key(ks_key), .ks_rcon(ks_rcon), .ks_next(ks_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int excl_viol = 0;
    int gate_viol = 0;

    logic [7:0]   sbox [256];
    logic [7:0]   rc_q [$];
    bit           fin_q [$];
    logic [127:0] key_q [$];
    int           icyc_q [$];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte i of the block is row i%4, column i/4 of the AES state.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = a[r+4*((c+r)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                logic [7:0] b0, b1, b2, b3;
                b0 = t[4*c]; b1 = t[4*c+1]; b2 = t[4*c+2]; b3 = t[4*c+3];
                t[4*c]   = gmul(b0, 8'd2) ^ gmul(b1, 8'd3) ^ b2 ^ b3;
                t[4*c+1] = b0 ^ gmul(b1, 8'd2) ^ gmul(b2, 8'd3) ^ b3;
                t[4*c+2] = b0 ^ b1 ^ gmul(b2, 8'd2) ^ gmul(b3, 8'd3);
                t[4*c+3] = gmul(b0, 8'd3) ^ b1 ^ b2 ^ gmul(b3, 8'd2);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s, k;
        logic [7:0]   rc;
        s = pt ^ key;
        k = key;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            k  = key_step(k, rc);
            s  = aes_round(s, k, r == 10);
            rc = xt(rc);
        end
        return s;
    endfunction

    // External key-schedule step (combinational) and round datapath (one register).
    always_comb ks_next = key_step(ks_key, ks_rcon);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dp_issue) dp_result <= aes_round(dp_state, dp_key, dp_final);
    end

    always @(negedge clk) begin
        if (dp_issue) begin
            rc_q.push_back(ks_rcon);
            fin_q.push_back(dp_final);
            key_q.push_back(dp_key);
            icyc_q.push_back(cyc);
        end
        if (in_ready && out_valid) excl_viol++;
        if (!dp_issue && (dp_state != '0 || dp_key != '0 || dp_final)) gate_viol++;
        if (!out_valid && out_state != '0) gate_viol++;
    end

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_in_ready"},  128'(in_ready),  128'd1);
        check_eq({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        check_eq({tag, "_out_state"}, out_state,       128'd0);
        check_eq({tag, "_dp_issue"},  128'(dp_issue),  128'd0);
        check_eq({tag, "_dp_final"},  128'(dp_final),  128'd0);
        check_eq({tag, "_dp_state"},  dp_state,        128'd0);
        check_eq({tag, "_dp_key"},    dp_key,          128'd0);
        check_eq({tag, "_ks_key"},    ks_key,          128'd0);
        check_eq({tag, "_ks_rcon"},   128'(ks_rcon),   128'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the output handshake.
    task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] key,
                             input int hold, input bit keep_valid, output int acc, output int hs);
        int n, ov, bad, busy_rdy, unstable;
        logic [127:0] ct, exp_ct;
        logic [79:0]  rv;
        logic [9:0]   fv;
        exp_ct = aes_encrypt(pt, key);
        rc_q.delete(); fin_q.delete(); key_q.delete(); icyc_q.delete();
        in_state  = pt;
        in_key    = key;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        check_eq({tag, "_accept"}, 128'(in_ready), 128'd1);
        acc = cyc + 1;
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
        busy_rdy = 0;
        n = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) busy_rdy++;
            @(negedge clk);
            n++;
        end
        ov = cyc;
        check_eq({tag, "_latency"}, 128'(ov - acc), 128'd20);
        check_eq({tag, "_ct"}, out_state, exp_ct);
        ct = out_state;
        unstable = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (out_state !== ct || !out_valid) unstable++;
            if (in_ready) busy_rdy++;
        end
        out_ready = 1'b1;
        hs = cyc + 1;
        @(negedge clk);
        check_eq({tag, "_idle_after_hs"}, {126'd0, in_ready, out_valid}, 128'd2);
        check_eq({tag, "_busy_in_ready"}, 128'(busy_rdy), 128'd0);
        check_eq({tag, "_hold_stable"}, 128'(unstable), 128'd0);
        rv = '0;
        fv = '0;
        bad = 0;
        for (int i = 0; i < rc_q.size(); i++) begin
            rv = {rv[71:0], rc_q[i]};
            fv = {fv[8:0], fin_q[i]};
            if (i > 0 && icyc_q[i] - icyc_q[i-1] != 2) bad++;
        end
        check_eq({tag, "_issues"}, 128'(rc_q.size()), 128'd10);
        check_eq({tag, "_rcon_seq"}, 128'(rv), 128'(80'h01020408102040801b36));
        check_eq({tag, "_final_pos"}, 128'(fv), 128'h001);
        check_eq({tag, "_issue_spacing"}, 128'(bad), 128'd0);
    endtask

    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        int acc, hs, acc_prev, hs_prev, ov_seen;
        logic [127:0] rk, rp;

        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_state = '0; in_key = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_idle_outputs("reset");

        // FIPS-197 Appendix B with fixed ciphertext and tenth round key.
        run_block("appB", B_PT, B_KEY, 0, 1'b0, acc, hs);
        check_eq("appB_ct_fips", dp_result, B_CT);
        check_eq("appB_key10", key_q.size() == 10 ? key_q[9] : 128'd0,
                 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // FIPS-197 C.1: the model's output is also pinned to the published value.
        run_block("c1", 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                  0, 1'b0, acc, hs);
        check_eq("c1_ct_fips", dp_result, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // Backpressure with in_valid held high, then the next block one cycle after release.
        rk = {$urandom, $urandom, $urandom, $urandom};
        rp = {$urandom, $urandom, $urandom, $urandom};
        run_block("bp", rp, rk, 7, 1'b1, acc, hs_prev);
        rk = {$urandom, $urandom, $urandom, $urandom};
        rp = {$urandom, $urandom, $urandom, $urandom};
        run_block("bp_next", rp, rk, 0, 1'b0, acc, hs);
        check_eq("bp_next_accept_gap", 128'(acc - hs_prev), 128'd1);

        // Abort mid-block by reset after the fifth round issue.
        rc_q.delete(); fin_q.delete(); key_q.delete(); icyc_q.delete();
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int n = 0; n < 40 && rc_q.size() < 5; n++) @(negedge clk);
        check_eq("rst_mid_issues_before", 128'(rc_q.size()), 128'd5);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_outputs("rst_mid");
        ov_seen = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        check_eq("rst_mid_no_output", 128'(ov_seen), 128'd0);
        run_block("appB_after_rst", B_PT, B_KEY, 0, 1'b0, acc, hs);
        check_eq("appB_after_rst_ct_fips", dp_result, B_CT);

        // Three back-to-back random blocks with out_ready tied high.
        acc_prev = 0;
        for (int i = 0; i < 3; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            run_block($sformatf("b2b%0d", i), rp, rk, 0, 1'b0, acc, hs);
            if (i > 0) check_eq($sformatf("b2b%0d_period", i), 128'(acc - acc_prev), 128'd22);
            acc_prev = acc;
        end

        check_eq("ready_valid_exclusive", 128'(excl_viol), 128'd0);
        check_eq("output_gating", 128'(gate_viol), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
